rsa_cmd_ctrl: RTL
=================

# rsa_cmd_ctrl

Parametrised command controller that sits between the Arm mailbox (command, done, and 1024-bit data handshakes) and a modular-arithmetic core (Montgomery multiplier or exponentiator). It owns a bank of `NUM_SLOTS` addressable operand registers and launches the core with a selectable mode. It waits for core completion under a timeout watchdog, captures the result, and reports a status code with every done.

## Interface
- `TX_SIZE`, 1024, width of data transfers, operands and result
- `NUM_SLOTS`, 4, operand registers (2..16)
- `TIMEOUT_CYCLES`, 65536, maximum cycles waited for `core_done` after `core_start`
- `clk`  in  1  single clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `arm_to_fpga_cmd`  in  32  command word: [3:0] opcode, [7:4] slot index
- `arm_to_fpga_cmd_valid`  in  1  command qualifier
- `fpga_to_arm_done`  out  1  command finished, held until read
- `fpga_to_arm_done_read`  in  1  Arm acknowledges done
- `fpga_to_arm_status`  out  2  00 ok, 01 bad command/slot, 10 timeout; valid while done=1
- `arm_to_fpga_data_valid` / `arm_to_fpga_data_ready`  in/out  1  load handshake
- `arm_to_fpga_data`  in  TX_SIZE  load data
- `fpga_to_arm_data_valid` / `fpga_to_arm_data_ready`  out/in  1  readback handshake
- `fpga_to_arm_data`  out  TX_SIZE  result register
- `core_start`  out  1  one-cycle launch pulse
- `core_mode`  out  1  0 Montgomery, 1 exponentiation; stable from START until DONE
- `core_operands`  out  NUM_SLOTS*TX_SIZE  slot k at bits [k*TX_SIZE +: TX_SIZE]
- `core_done`  in  1  core completion pulse/level
- `core_result`  in  TX_SIZE  valid when `core_done`=1
- `leds`  out  4  {status!=0, state[2:0]}

## Operation
- Opcodes: 0 LOAD slot, 1 COMPUTE_EXP, 3 COMPUTE_MONT, 4 READ_RESULT. Any other opcode, or LOAD with slot ≥ NUM_SLOTS, goes straight to DONE with status 01 and no state change.
- States: IDLE, LOAD, START, WAIT_CORE, WRITE, DONE.
- IDLE: on `cmd_valid`, decode → LOAD / START (mode latched) / WRITE / DONE(err). Status clears to 00 on every accepted command. `cmd_valid` outside IDLE is ignored.
- LOAD: `data_ready`=1; on `data_valid`, write slot[idx] ← data, → DONE.
- START: `core_start`=1 for exactly this cycle, watchdog counter ← 0, → WAIT_CORE.
- WAIT_CORE: counter increments each cycle. `core_done` → result ← `core_result`, → DONE. Counter == TIMEOUT_CYCLES-1 without `core_done` → status 10, result unchanged, → DONE. If `core_done` arrives in the timeout cycle, done wins (status 00, result captured).
- WRITE: `data_out_valid`=1 with result; on `data_ready`, → DONE.
- DONE: `fpga_to_arm_done`=1; on `done_read`, → IDLE.
- Slots and result persist across commands; only reset clears them.

## Timing
- All outputs are Moore decodes of the registered state, asserted from the first cycle in the state, with no extra register delay.
- Reset (async assert, synchronous release): state IDLE; all slots, result, status, counter = 0. All outputs low/zero: `done`, both valids/readys, `core_start`, `core_mode`, `core_operands`, `fpga_to_arm_data`, `status`, `leds`.
- Reset mid-WAIT_CORE abandons the operation. A later `core_done` while not in WAIT_CORE is ignored.
- Command to `done` latency:
  - LOAD with data already valid: 2 cycles (IDLE→LOAD→DONE).
  - Compute: 3 cycles + core latency.
  - Bad command: 1 cycle.
- Handshake transfers occur on the cycle where valid and ready are both high; the state leaves on the following edge.
- `done_read` held high is consumed once; the next command needs IDLE.

## Test plan
- Reset, LOAD slot 2 ← 0xA5…A5 (data_valid 3 cycles late) → data_ready high 4 cycles, `core_operands` slot 2 = 0xA5…A5, done=1, status 00; other slots 0.
- COMPUTE_MONT, model core returns 0x1234 after 10 cycles → one-cycle `core_start`, `core_mode`=0, done 13 cycles after cmd. READ_RESULT with ready → data 0x1234.
- COMPUTE_EXP, TIMEOUT_CYCLES=16, core silent → done 18 cycles after cmd, status 10, result unchanged, leds[3]=1.
- `core_done` exactly in the timeout cycle → status 00, result captured.
- Opcode 7, then LOAD slot 15 with NUM_SLOTS=4 → done next cycle, status 01, slots unchanged; `cmd_valid` pulses during DONE are ignored.
- Assert resetn low during WAIT_CORE and READ_RESULT → all outputs 0 immediately, IDLE after release, a stale `core_done` is ignored.

Source files
------------

// File: rtl/rsa_cmd_ctrl.sv
// Command controller between the Arm mailbox and a modular-arithmetic core:
// owns the operand slots and result register, launches the core and runs a timeout watchdog.
module rsa_cmd_ctrl #(
  parameter int TX_SIZE        = 1024,
  parameter int NUM_SLOTS      = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [31:0]                    arm_to_fpga_cmd,
  input  logic                           arm_to_fpga_cmd_valid,
  output logic                           fpga_to_arm_done,
  input  logic                           fpga_to_arm_done_read,
  output logic [1:0]                     fpga_to_arm_status,
  input  logic                           arm_to_fpga_data_valid,
  output logic                           arm_to_fpga_data_ready,
  input  logic [TX_SIZE-1:0]             arm_to_fpga_data,
  output logic                           fpga_to_arm_data_valid,
  input  logic                           fpga_to_arm_data_ready,
  output logic [TX_SIZE-1:0]             fpga_to_arm_data,
  output logic                           core_start,
  output logic                           core_mode,
  output logic [NUM_SLOTS*TX_SIZE-1:0]   core_operands,
  input  logic                           core_done,
  input  logic [TX_SIZE-1:0]             core_result,
  output logic [3:0]                     leds
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] OP_LOAD = 4'd0;
  localparam logic [3:0] OP_EXP  = 4'd1;
  localparam logic [3:0] OP_MONT = 4'd3;
  localparam logic [3:0] OP_READ = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_BAD     = 2'b01,
    ST_TIMEOUT = 2'b10
  } status_e;

  state_e                               state_q, state_d;
  status_e                              status_q, status_d;
  logic [3:0]                           slot_q, slot_d;
  logic                                 mode_q, mode_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic [TX_SIZE-1:0]                   result_q, result_d;
  logic [NUM_SLOTS-1:0][TX_SIZE-1:0]    slots_q, slots_d;

  logic [3:0]  cmd_op;
  logic [3:0]  cmd_slot;
  logic [23:0] unused_cmd_bits;

  assign cmd_op          = arm_to_fpga_cmd[3:0];
  assign cmd_slot        = arm_to_fpga_cmd[7:4];
  assign unused_cmd_bits = arm_to_fpga_cmd[31:8];

  always_comb begin
    // NOTE: every _d defaults to its _q before the case so no path can infer a latch.
    state_d  = state_q;
    status_d = status_q;
    slot_d   = slot_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    slots_d  = slots_q;

    unique case (state_q)
      S_IDLE: begin
        if (arm_to_fpga_cmd_valid) begin
          status_d = ST_OK;
          case (cmd_op)
            OP_LOAD: begin
              if (int'(cmd_slot) < NUM_SLOTS) begin
                slot_d  = cmd_slot;
                state_d = S_LOAD;
              end else begin
                status_d = ST_BAD;
                state_d  = S_DONE;
              end
            end
            OP_EXP: begin
              mode_d  = 1'b1;
              state_d = S_START;
            end
            OP_MONT: begin
              mode_d  = 1'b0;
              state_d = S_START;
            end
            OP_READ: state_d = S_WRITE;
            default: begin
              status_d = ST_BAD;
              state_d  = S_DONE;
            end
          endcase
        end
      end

      S_LOAD: begin
        if (arm_to_fpga_data_valid) begin
          for (int k = 0; k < NUM_SLOTS; k++) begin
            if (slot_q == 4'(k)) slots_d[k] = arm_to_fpga_data;
          end
          state_d = S_DONE;
        end
      end

      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      // A core_done landing on the last watchdog cycle still counts as success.
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (core_done) begin
          result_d = core_result;
          state_d  = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          status_d = ST_TIMEOUT;
          state_d  = S_DONE;
        end
      end

      S_WRITE: begin
        if (fpga_to_arm_data_ready) state_d = S_DONE;
      end

      S_DONE: begin
        if (fpga_to_arm_done_read) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      status_q <= ST_OK;
      slot_q   <= '0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      // NOTE: the operand bank is reset like ordinary flops so core_operands reads zero out of reset.
      slots_q  <= '0;
    end else begin
      // NOTE: non-blocking only in sequential blocks; blocking here would race with readers on the same edge.
      state_q  <= state_d;
      status_q <= status_d;
      slot_q   <= slot_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      slots_q  <= slots_d;
    end
  end

  assign fpga_to_arm_done       = (state_q == S_DONE);
  assign arm_to_fpga_data_ready = (state_q == S_LOAD);
  assign fpga_to_arm_data_valid = (state_q == S_WRITE);
  assign core_start             = (state_q == S_START);
  assign core_mode              = mode_q;
  assign core_operands          = slots_q;
  assign fpga_to_arm_data       = result_q;
  assign fpga_to_arm_status     = status_q;
  assign leds                   = {status_q != ST_OK, state_q};

endmodule
